// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: shared funct3 encodings, FSM states and strobe width for the memory access unit
package riscv_mem_pkg;
  localparam int WSTRB_W = 4;
  localparam logic [2:0] F3_B = 3'b000, F3_H = 3'b001, F3_W = 3'b010, F3_BU = 3'b100, F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} mem_state_t;
  function automatic logic f3_legal(input logic [2:0] f3);
    return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: store lane replication/strobes and load lane extraction/extension
module mem_lane_align
  import riscv_mem_pkg::*;
(
  input  logic [2:0]         st_funct3,
  input  logic [1:0]         st_off,
  input  logic [31:0]        st_data,
  output logic [31:0]        st_wdata,
  output logic [WSTRB_W-1:0] st_wstrb,
  input  logic [2:0]         ld_funct3,
  input  logic [1:0]         ld_off,
  input  logic [31:0]        ld_rdata,
  output logic [31:0]        ld_data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    st_wdata = st_funct3[1] ? st_data : st_funct3[0] ? {2{st_data[15:0]}} : {4{st_data[7:0]}};
    st_wstrb = st_funct3[1] ? 4'b1111 : (st_funct3[0] ? 4'b0011 : 4'b0001) << st_off;
    b = ld_rdata[{ld_off, 3'b000} +: 8];
    h = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    ld_data = ld_funct3[1] ? ld_rdata
            : ld_funct3[0] ? {{16{h[15] & ~ld_funct3[2]}}, h}
            : {{24{b[7] & ~ld_funct3[2]}}, b};
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: IM-stage load/store engine driving a valid/ready memory port, stalling while busy
module mem_access_unit
  import riscv_mem_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_valid,
  input  logic                  i_ctrl_mem_rd,
  input  logic                  i_ctrl_mem_wr,
  input  logic [2:0]            i_ctrl_funct3,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_stall,
  output logic                  o_fault,
  output logic                  o_mem_req_valid,
  input  logic                  i_mem_req_ready,
  output logic                  o_mem_req_we,
  output logic [ADDR_WIDTH-1:0] o_mem_req_addr,
  output logic [DATA_WIDTH-1:0] o_mem_req_wdata,
  output logic [WSTRB_W-1:0]    o_mem_req_wstrb,
  input  logic                  i_mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] i_mem_rsp_rdata
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  mem_state_t state, state_n;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, st_wdata, ld_data;
  logic [WSTRB_W-1:0]    wstrb_q, st_wstrb;
  logic                  we_q, fault_q, access, bad, tmo;
  logic [2:0]            f3_q;
  logic [1:0]            off_q;
  logic [CW-1:0]         cnt;

  mem_lane_align u_align (
    .st_funct3(i_ctrl_funct3),
    .st_off   (i_addr[1:0]),
    .st_data  (i_wr_data),
    .st_wdata (st_wdata),
    .st_wstrb (st_wstrb),
    .ld_funct3(f3_q),
    .ld_off   (off_q),
    .ld_rdata (i_mem_rsp_rdata),
    .ld_data  (ld_data)
  );

  always_comb begin
    access = i_valid & (i_ctrl_mem_rd | i_ctrl_mem_wr);
    bad = (i_ctrl_mem_rd & i_ctrl_mem_wr) | ~f3_legal(i_ctrl_funct3)
        | (i_ctrl_funct3[0] & i_addr[0]) | (i_ctrl_funct3[1] & |i_addr[1:0]);
    tmo = cnt == CW'(TIMEOUT_CYCLES - 1);
    state_n = state == IDLE ? (access ? (bad ? DONE : REQ) : IDLE)
            : state == REQ  ? (tmo ? DONE : i_mem_req_ready ? WAIT : REQ)
            : state == WAIT ? ((tmo | i_mem_rsp_valid) ? DONE : WAIT)
            : IDLE;
    o_stall = state == REQ | state == WAIT | (state == IDLE & access);
    o_fault = state == DONE & fault_q;
    o_mem_req_valid = state == REQ;
    o_mem_req_we = we_q;
    o_mem_req_addr = addr_q;
    o_mem_req_wdata = wdata_q;
    o_mem_req_wstrb = wstrb_q;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state     <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      we_q      <= 1'b0;
      f3_q      <= '0;
      off_q     <= '0;
      fault_q   <= 1'b0;
      cnt       <= '0;
      o_rd_data <= '0;
    end else begin
      state <= state_n;
      cnt   <= (state == REQ || state == WAIT) ? cnt + 1'b1 : '0;
      if (state == IDLE && access) begin
        fault_q <= bad;
        addr_q  <= {i_addr[ADDR_WIDTH-1:2], 2'b00};
        wdata_q <= i_ctrl_mem_wr ? st_wdata : '0;
        wstrb_q <= i_ctrl_mem_wr ? st_wstrb : '0;
        we_q    <= i_ctrl_mem_wr;
        f3_q    <= i_ctrl_funct3;
        off_q   <= i_addr[1:0];
        if (bad) o_rd_data <= '0;
      end
      // a response arriving on the final WAIT cycle still completes the access
      if ((state == REQ && tmo) || (state == WAIT && tmo && !i_mem_rsp_valid)) begin
        fault_q   <= 1'b1;
        o_rd_data <= '0;
      end else if (state == WAIT && i_mem_rsp_valid && !we_q) begin
        o_rd_data <= ld_data;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for the memory access unit with a scripted memory responder
module tb_mem_access_unit;
  import riscv_mem_pkg::*;
  localparam int TMO = 255;

  logic        i_clk = 0, i_reset_n = 0, i_valid = 0, i_ctrl_mem_rd = 0, i_ctrl_mem_wr = 0;
  logic [2:0]  i_ctrl_funct3 = 0;
  logic [31:0] i_addr = 0, i_wr_data = 0, i_mem_rsp_rdata = 0;
  logic        i_mem_req_ready = 0, i_mem_rsp_valid = 0;
  logic [31:0] o_rd_data, o_mem_req_addr, o_mem_req_wdata;
  logic        o_stall, o_fault, o_mem_req_valid, o_mem_req_we;
  logic [3:0]  o_mem_req_wstrb;

  typedef struct {
    logic [31:0] rd;
    logic        flt;
    int          stall;
  } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;

  mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_valid(i_valid),
    .i_ctrl_mem_rd(i_ctrl_mem_rd), .i_ctrl_mem_wr(i_ctrl_mem_wr), .i_ctrl_funct3(i_ctrl_funct3),
    .i_addr(i_addr), .i_wr_data(i_wr_data), .o_rd_data(o_rd_data), .o_stall(o_stall), .o_fault(o_fault),
    .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(i_mem_req_ready), .o_mem_req_we(o_mem_req_we),
    .o_mem_req_addr(o_mem_req_addr), .o_mem_req_wdata(o_mem_req_wdata), .o_mem_req_wstrb(o_mem_req_wstrb),
    .i_mem_rsp_valid(i_mem_rsp_valid), .i_mem_rsp_rdata(i_mem_rsp_rdata)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // rdy_dly: cycles ready stays low; rsp_dly: WAIT cycle carrying the response (0 = never)
  task automatic access(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input int rdy_dly, input int rsp_dly,
                        input logic [31:0] rdata, input logic [31:0] exp_rd, input logic exp_flt,
                        input logic [31:0] exp_addr, input logic [3:0] exp_strb, input logic [31:0] exp_wd);
    exp_t e, x;
    int rv = 0, wn = 0, st = 1;
    logic acc = 0, hs;
    e.rd = exp_rd;
    e.flt = exp_flt;
    e.stall = exp_flt ? (rsp_dly == 0 ? 1 + TMO : 1) : 2 + rdy_dly + rsp_dly;
    sb.push_back(e);
    @(negedge i_clk);
    i_valid = 1; i_ctrl_mem_rd = rd; i_ctrl_mem_wr = wr; i_ctrl_funct3 = f3; i_addr = addr; i_wr_data = wd;
    #1 chk({tag, "_stall_idle"}, o_stall, 1);
    for (int n = 0; n < 400; n++) begin
      hs = o_mem_req_valid && rv >= rdy_dly;
      if (o_mem_req_valid) begin
        chk({tag, "_addr"}, o_mem_req_addr, exp_addr);
        chk({tag, "_we"}, o_mem_req_we, wr);
        chk({tag, "_wstrb"}, o_mem_req_wstrb, exp_strb);
        if (wr) chk({tag, "_wdata"}, o_mem_req_wdata, exp_wd);
        rv++;
      end
      if (acc && !o_mem_req_valid) wn++;
      i_mem_req_ready = hs;
      i_mem_rsp_valid = acc && rsp_dly != 0 && wn == rsp_dly;
      i_mem_rsp_rdata = i_mem_rsp_valid ? rdata : $urandom;
      @(posedge i_clk);
      #1;
      i_mem_req_ready = 0;
      i_mem_rsp_valid = 0;
      if (hs) acc = 1;
      if (!o_stall) break;
      st++;
    end
    x = sb.pop_front();
    chk({tag, "_req_issued"}, rv != 0, x.stall > 1);
    chk({tag, "_rd_data"}, o_rd_data, x.rd);
    chk({tag, "_fault"}, o_fault, x.flt);
    chk({tag, "_stall_cycles"}, st, x.stall);
    i_valid = 0; i_ctrl_mem_rd = 0; i_ctrl_mem_wr = 0;
    @(posedge i_clk);
    #1;
    chk({tag, "_fault_pulse"}, o_fault, 0);
    chk({tag, "_req_idle"}, o_mem_req_valid, 0);
    chk({tag, "_rd_hold"}, o_rd_data, x.rd);
  endtask

  initial begin
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_rd", o_rd_data, 0);
    chk("rst_valid", o_mem_req_valid, 0);
    chk("rst_stall", o_stall, 0);
    chk("rst_fault", o_fault, 0);
    chk("rst_addr", o_mem_req_addr, 0);
    chk("rst_wstrb", o_mem_req_wstrb, 0);
    @(negedge i_clk);
    i_reset_n = 1;
    access("lw",     1, 0, F3_W,  32'h10, 0, 0, 2, 32'hDEADBEEF, 32'hDEADBEEF, 0, 32'h10, 4'b0000, 0);
    access("lb",     1, 0, F3_B,  32'h13, 0, 0, 1, 32'h80FF0000, 32'hFFFFFF80, 0, 32'h10, 4'b0000, 0);
    access("lbu",    1, 0, F3_BU, 32'h13, 0, 1, 1, 32'h80FF0000, 32'h00000080, 0, 32'h10, 4'b0000, 0);
    access("lh",     1, 0, F3_H,  32'h12, 0, 0, 1, 32'h80FF0000, 32'hFFFF80FF, 0, 32'h10, 4'b0000, 0);
    access("sh",     0, 1, F3_H,  32'h22, 32'h1234ABCD, 3, 1, 0, 32'hFFFF80FF, 0, 32'h20, 4'b1100, 32'hABCDABCD);
    access("sb",     0, 1, F3_B,  32'h21, 32'h000000A5, 0, 1, 0, 32'hFFFF80FF, 0, 32'h20, 4'b0010, 32'hA5A5A5A5);
    access("sw",     0, 1, F3_W,  32'h24, 32'h11223344, 1, 2, 0, 32'hFFFF80FF, 0, 32'h24, 4'b1111, 32'h11223344);
    access("lhu",    1, 0, F3_HU, 32'h16, 0, 0, 1, 32'h9ABC1234, 32'h00009ABC, 0, 32'h14, 4'b0000, 0);
    access("lw_mis", 1, 0, F3_W,  32'h06, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    access("lb_pos", 1, 0, F3_B,  32'h11, 0, 0, 1, 32'h00007F00, 32'h0000007F, 0, 32'h10, 4'b0000, 0);
    access("sh_mis", 0, 1, F3_H,  32'h01, 32'h5555, 0, 1, 0, 0, 1, 0, 0, 0);
    access("lw2",    1, 0, F3_W,  32'h30, 0, 0, 3, 32'h13579BDF, 32'h13579BDF, 0, 32'h30, 4'b0000, 0);
    access("f3_bad", 1, 0, 3'b011, 32'h30, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    access("lbu2",   1, 0, F3_BU, 32'h32, 0, 0, 1, 32'h00AB0000, 32'h000000AB, 0, 32'h30, 4'b0000, 0);
    access("rdwr",   1, 1, F3_W,  32'h30, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    access("lh_pre", 1, 0, F3_H,  32'h12, 0, 0, 1, 32'h80FF0000, 32'hFFFF80FF, 0, 32'h10, 4'b0000, 0);
    access("tmo",    1, 0, F3_W,  32'h40, 0, 0, 0, 0, 0, 1, 32'h40, 4'b0000, 0);
    access("lh_pre2", 1, 0, F3_H, 32'h12, 0, 0, 1, 32'h80FF0000, 32'hFFFF80FF, 0, 32'h10, 4'b0000, 0);
    // reset while the load waits for its response, then a stale response arrives
    @(negedge i_clk);
    i_valid = 1; i_ctrl_mem_rd = 1; i_ctrl_funct3 = F3_W; i_addr = 32'h50;
    @(posedge i_clk);
    #1;
    chk("rstw_req", o_mem_req_valid, 1);
    i_mem_req_ready = 1;
    @(posedge i_clk);
    #1;
    i_mem_req_ready = 0;
    chk("rstw_wait_stall", o_stall, 1);
    i_reset_n = 0; i_valid = 0; i_ctrl_mem_rd = 0;
    @(posedge i_clk);
    #1;
    i_reset_n = 1;
    chk("rstw_valid", o_mem_req_valid, 0);
    chk("rstw_stall", o_stall, 0);
    chk("rstw_rd", o_rd_data, 0);
    chk("rstw_fault", o_fault, 0);
    @(posedge i_clk);
    #1;
    i_mem_rsp_valid = 1; i_mem_rsp_rdata = 32'hCAFEF00D;
    @(posedge i_clk);
    #1;
    i_mem_rsp_valid = 0;
    repeat (2) begin
      chk("late_rd", o_rd_data, 0);
      chk("late_fault", o_fault, 0);
      chk("late_stall", o_stall, 0);
      chk("late_valid", o_mem_req_valid, 0);
      @(posedge i_clk);
      #1;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Memory (IM) stage load/store engine that replaces the on-chip data_mem with a valid/ready request/response port toward the external DDR3 memory-controller bridge. It consumes the execute-stage ALU address, store data and memory control signals. It performs byte-lane steering and load sign/zero extension, and stalls the pipeline while an access is outstanding. Its registered load data feeds the IM→WB pipeline register.

Parameters:
DATA_WIDTH, 32, datapath width; only 32 is supported.
ADDR_WIDTH, 32, byte address width presented to the memory port.
TIMEOUT_CYCLES, 255, maximum cycles spent in REQ+WAIT before a fault; must be ≥1.

Ports:
i_clk  in  1  clock
i_reset_n  in  1  synchronous active-low reset
i_valid  in  1  a non-bubble instruction occupies the IM stage
i_ctrl_mem_rd  in  1  instruction is a load
i_ctrl_mem_wr  in  1  instruction is a store
i_ctrl_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
i_addr  in  ADDR_WIDTH  byte address from execute ALU result
i_wr_data  in  DATA_WIDTH  store data (rs2)
o_rd_data  out  DATA_WIDTH  extended load result, registered
o_stall  out  1  freeze IF/ID/IE/IM pipeline registers
o_fault  out  1  one-cycle pulse: misaligned, illegal, or timed-out access
o_mem_req_valid  out  1  request valid
i_mem_req_ready  in  1  controller accepts the request
o_mem_req_we  out  1  1 = write, 0 = read
o_mem_req_addr  out  ADDR_WIDTH  word-aligned address {i_addr[ADDR_WIDTH-1:2],2'b00}
o_mem_req_wdata  out  DATA_WIDTH  lane-replicated store data
o_mem_req_wstrb  out  4  byte enables
i_mem_rsp_valid  in  1  response or write-complete, one cycle
i_mem_rsp_rdata  in  DATA_WIDTH  read word, valid with i_mem_rsp_valid

Behaviour:
- Reset (synchronous, i_reset_n=0 at a clock edge):
  - state=IDLE.
  - All o_mem_req_* = 0, o_rd_data = 0, o_fault = 0, timeout counter = 0.
  - Reset mid-access drops o_mem_req_valid on the next cycle.
  - A response arriving after reset is ignored.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, access detection:
  - access = i_valid & (i_ctrl_mem_rd | i_ctrl_mem_wr).
  - o_stall is driven combinationally to 1 in IDLE while access=1.
  - No access: o_stall=0, o_rd_data holds its value.
- IDLE, fault check: rd&wr both set, undefined funct3, H with addr[0]=1, or W with addr[1:0]≠0.
  - Go to DONE with fault flag set.
  - No request is issued; o_rd_data ← 0.
- IDLE, legal access:
  - Register address, wdata, wstrb, we, funct3 and addr[1:0]; go to REQ.
- REQ:
  - o_mem_req_valid=1; request fields stay stable until the handshake.
  - On i_mem_req_ready → WAIT.
  - i_mem_rsp_valid in REQ is ignored.
- WAIT:
  - On i_mem_rsp_valid → DONE.
  - For loads, o_rd_data ← extended lane of i_mem_rsp_rdata.
  - For stores, o_rd_data holds its value.
- Timeout:
  - Counter clears on IDLE→REQ and increments every cycle in REQ or WAIT.
  - Reaching TIMEOUT_CYCLES → DONE with fault; o_mem_req_valid deasserts; o_rd_data ← 0.
- DONE:
  - o_stall=0, so the pipeline advances at this edge.
  - o_fault=1 if the fault flag is set.
  - Next state is IDLE unconditionally.
  - A new access therefore re-stalls the following cycle.
- Minimum stall with ready=1 and response 1 cycle after acceptance: stall in IDLE, REQ, WAIT; DONE is the release cycle.
- Store lanes:
  - SB: wdata={4{d[7:0]}}, wstrb=4'b0001<<addr[1:0].
  - SH: wdata={2{d[15:0]}}, wstrb=4'b0011<<addr[1:0].
  - SW: wdata=d, wstrb=4'b1111.
  - Loads: wstrb=0, we=0.
- Load extract: byte or half selected by the registered addr[1:0]; B/H sign-extend, BU/HU zero-extend, W passes through.

Decomposition:
- Package riscv_mem_pkg holds:
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU;
  - typedef enum mem_state_t {IDLE,REQ,WAIT,DONE};
  - the wstrb width constant.
- One combinational sub-module, mem_lane_align: store replication/strobe generation and load extraction/extension.

Test Plan:
- LW i_addr=0x10, ready=1, rsp 2 cycles after acceptance with rdata=0xDEADBEEF → req addr=0x10, wstrb=0, we=0; o_rd_data=0xDEADBEEF in DONE; stall released exactly at DONE.
- LB then LBU at i_addr=0x13, rdata=0x80FF0000 → o_rd_data=0xFFFFFF80, then 0x00000080; LH at 0x12 with rdata=0x80FF0000 → 0xFFFF80FF.
- SH i_addr=0x22, i_wr_data=0x1234ABCD, ready held low 3 cycles → valid and fields stable for the 3 cycles; addr=0x20, wdata=0xABCDABCD, wstrb=4'b1100, we=1.
- LW at 0x06 and SH at 0x01 → no o_mem_req_valid; o_fault pulses 1 cycle; o_rd_data=0; exactly one stall cycle each.
- LW with no response ever → o_fault in DONE after 255 cycles in REQ+WAIT; req_valid low afterwards.
- Reset asserted during WAIT, late rsp_valid 2 cycles later → state IDLE, req_valid=0, o_stall=0, o_rd_data=0, no fault.
